// File: rtl/bram_stream_reader_if.sv
// rtl/bram_stream_reader_if.sv - valid/ready word stream from the BRAM reader
interface bram_stream_reader_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;

  modport master (output m_valid, output m_data, output m_last, input m_ready);
  modport slave  (input m_valid, input m_data, input m_last, output m_ready);
endinterface

// File: rtl/bram_stream_reader.sv
// rtl/bram_stream_reader.sv - reads a block of BRAM words out onto a stream
// The 3-entry FIFO absorbs the one-cycle RAM latency so reads can be issued ahead of the consumer.
module bram_stream_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  output logic                  busy,
  output logic                  done,
  output logic                  bram_en,
  output logic                  bram_we,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  input  logic [DATA_WIDTH-1:0] bram_dout,
  bram_stream_reader_if.master  m
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  rem_q;
  logic                  inflight_q;
  logic                  inflight_last_q;
  logic [1:0]            count_q;
  logic [1:0]            rd_ptr_q;
  logic [1:0]            wr_ptr_q;
  logic [DATA_WIDTH-1:0] mem_data [3];
  logic                  mem_last [3];

  logic issue;
  logic push;
  logic pop;
  logic last_pop;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Issue decision looks only at registered state, so m_ready never reaches bram_en.
  assign issue    = (state_q == S_RUN) && (rem_q != '0) &&
                    (({1'b0, count_q} + {2'b00, inflight_q}) < 3'd3);
  assign push     = inflight_q;
  assign pop      = (count_q != 2'd0) && m.m_ready;
  assign last_pop = pop && mem_last[rd_ptr_q];

  assign bram_en   = issue;
  assign bram_we   = 1'b0;
  assign bram_addr = addr_q;
  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);

  assign m.m_valid = (count_q != 2'd0);
  assign m.m_data  = mem_data[rd_ptr_q];
  assign m.m_last  = mem_last[rd_ptr_q];

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = (length == '0) ? S_DONE : S_RUN;
      S_RUN:  if (last_pop) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_IDLE;
      addr_q          <= '0;
      rem_q           <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      count_q         <= 2'd0;
      rd_ptr_q        <= 2'd0;
      wr_ptr_q        <= 2'd0;
      for (int i = 0; i < 3; i++) begin
        mem_data[i] <= '0;
        mem_last[i] <= 1'b0;
      end
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && start) begin
        addr_q <= base_addr;
        rem_q  <= length;
      end
      if (issue) begin
        addr_q <= addr_q + ADDR_WIDTH'(1);
        rem_q  <= rem_q - LEN_WIDTH'(1);
      end
      inflight_q      <= issue;
      inflight_last_q <= issue && (rem_q == LEN_WIDTH'(1));

      // RAM output changes every clock, so it is captured only in the cycle after an issue.
      if (push) begin
        mem_data[wr_ptr_q] <= bram_dout;
        mem_last[wr_ptr_q] <= inflight_last_q;
        wr_ptr_q           <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);

      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_stream_reader.sv
// tb/tb_bram_stream_reader.sv - directed vector bench for bram_stream_reader
module tb_bram_stream_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] length;
  logic        busy, done, bram_en, bram_we;
  logic [31:0] bram_addr;
  logic [31:0] bram_dout;
  int unsigned cyc_ctr = 0;

  int checks = 0;
  int errors = 0;

  bram_stream_reader_if #(.DATA_WIDTH(32)) s_if ();

  bram_stream_reader #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .LEN_WIDTH(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .bram_en   (bram_en),
    .bram_we   (bram_we),
    .bram_addr (bram_addr),
    .bram_dout (bram_dout),
    .m         (s_if.master)
  );

  always #5 clk = ~clk;

  // RAM[i] = i; with the port idle the output register carries junk that changes every clock
  always @(posedge clk) begin
    cyc_ctr   <= cyc_ctr + 1;
    bram_dout <= bram_en ? bram_addr : (32'hBAD0_0000 ^ cyc_ctr);
  end

  typedef struct {
    logic [31:0] base;
    logic [15:0] len;
    logic [3:0]  ready_pat;
    bit          poke;
    logic [31:0] exp_first;
    logic [31:0] exp_final;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic run_xfer(input vec_t v);
    int          got = 0;
    int          en_cnt = 0;
    int          cyc = 0;
    int          first_valid = -1;
    int          last_hs = -1;
    bit          done_seen = 0;
    logic [31:0] first_word = 32'hFFFF_FFFF;
    logic [31:0] final_word = 32'hFFFF_FFFF;
    @(negedge clk);
    start = 1'b1; base_addr = v.base; length = v.len; s_if.m_ready = v.ready_pat[0];
    @(negedge clk);
    cyc = 1;
    chk("busy_cycle1", busy, (v.len != 0));
    while (cyc < 300) begin
      s_if.m_ready = v.ready_pat[cyc % 4];
      if (v.poke && cyc == 3) begin
        start = 1'b1; base_addr = 32'h999; length = 16'd50;
      end else begin
        start = 1'b0;
      end
      if (bram_we !== 1'b0) chk("bram_we", bram_we, 1'b0);
      if (bram_en) en_cnt++;
      if (s_if.m_valid && first_valid < 0) first_valid = cyc;
      if (s_if.m_valid && s_if.m_ready) begin
        if (s_if.m_data !== v.base + got) chk("word_data", s_if.m_data, v.base + got);
        if (s_if.m_last !== (got == v.len - 1)) chk("word_last", s_if.m_last, (got == v.len - 1));
        if (got == 0) first_word = s_if.m_data;
        final_word = s_if.m_data;
        got++;
        if (got == v.len) last_hs = cyc;
      end
      if (done) begin
        done_seen = 1;
        chk("busy_in_done", busy, 1'b0);
        if (v.len == 0) chk("done_cycle_len0", cyc, 1);
        else            chk("done_after_last", cyc, last_hs + 1);
        break;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk("done_seen", done_seen, 1'b1);
    chk("word_count", got, v.len);
    chk("issue_count", en_cnt, v.len);
    if (v.len == 0) begin
      chk("no_valid_len0", first_valid, -1);
    end else begin
      chk("first_valid_cycle", first_valid, 3);
      chk("first_word", first_word, v.exp_first);
      chk("final_word", final_word, v.exp_final);
    end
  endtask

  vec_t vecs [6];

  initial begin
    int hs;
    vecs[0] = '{32'h0000_0010, 16'd4, 4'b1111, 1'b0, 32'h0000_0010, 32'h0000_0013};
    vecs[1] = '{32'h0000_0000, 16'd0, 4'b1111, 1'b0, 32'h0000_0000, 32'h0000_0000};
    vecs[2] = '{32'h0000_0020, 16'd8, 4'b1001, 1'b0, 32'h0000_0020, 32'h0000_0027};
    vecs[3] = '{32'hFFFF_FFFE, 16'd3, 4'b1111, 1'b0, 32'hFFFF_FFFE, 32'h0000_0000};
    vecs[4] = '{32'h0000_0040, 16'd5, 4'b1111, 1'b1, 32'h0000_0040, 32'h0000_0044};
    vecs[5] = '{32'h0000_0060, 16'd7, 4'b1000, 1'b0, 32'h0000_0060, 32'h0000_0066};

    reset = 1'b1; start = 1'b0; base_addr = '0; length = '0; s_if.m_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_bram_en", bram_en, 1'b0);
    chk("rst_bram_addr", bram_addr, 32'h0);
    chk("rst_m_valid", s_if.m_valid, 1'b0);
    chk("rst_m_data", s_if.m_data, 32'h0);
    chk("rst_m_last", s_if.m_last, 1'b0);
    reset = 1'b0;

    // back-to-back: each transfer starts in the IDLE cycle following the previous DONE
    for (int i = 0; i < 6; i++) run_xfer(vecs[i]);

    // reset after two words of a six-word transfer
    @(negedge clk);
    start = 1'b1; base_addr = 32'h80; length = 16'd6; s_if.m_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hs = 0;
    for (int c = 0; c < 20 && hs < 2; c++) begin
      if (s_if.m_valid && s_if.m_ready) hs++;
      if (hs < 2) @(negedge clk);
    end
    chk("mid_rst_two_words", hs, 2);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_m_valid", s_if.m_valid, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_done", done, 1'b0);
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (done || s_if.m_valid || bram_en) chk("post_rst_quiet", {done, s_if.m_valid, bram_en}, 3'b000);
    end
    run_xfer('{32'h0000_0090, 16'd2, 4'b1111, 1'b0, 32'h0000_0090, 32'h0000_0091});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
